pc_fetch_ctrl: RTL and testbench

- Drives the instruction-fetch stage: generates `PC` and the `Stall`/`Flush` controls that IMEM consumes.
- Consumes IMEM's `UpdatedPC` as the sequential next PC.
- Arbitrates branch redirects, load-use hazards and external holds.
- Sits between the EX-stage branch resolution, ID-stage hazard information and IMEM.

---
 rtl/pc_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch PC controller: sequences PC and the Stall/Flush/bubble controls for IMEM.
// Optional `PC_ALIGN_CHECK_EN adds a sticky Misalign output and forces redirect targets word-aligned.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC    = 32'd0,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          PC_W         = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] UpdatedPC,
    input  logic            Branch_Taken,
    input  logic [PC_W-1:0] Branch_Target,
    input  logic            IdEx_MemRead,
    input  logic [4:0]      IdEx_Rd,
    input  logic [4:0]      IfId_Rs1,
    input  logic [4:0]      IfId_Rs2,
    input  logic            Ext_Hold,
    output logic [PC_W-1:0] PC,
    output logic            Stall,
    output logic            Flush,
    output logic            IdEx_Bubble
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            Misalign
`endif
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_RESET   = PC_W'(RESET_VEC);

    logic [1:0]      state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [PC_W-1:0] pend, pend_nxt;
    logic            pend_v, pend_v_nxt;
    logic            flush_q;
    logic            redirect;
    logic [PC_W-1:0] redirect_target;
    logic            lu;

    function automatic logic [PC_W-1:0] align_target(input logic [PC_W-1:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return {t[PC_W-1:2], 2'b00};
`else
        return t;
`endif
    endfunction

    assign lu = IdEx_MemRead && (IdEx_Rd != 5'd0) &&
                ((IdEx_Rd == IfId_Rs1) || (IdEx_Rd == IfId_Rs2));

    // A resolved branch squashes the dependent instruction, so it overrides the load-use stall.
    assign Stall       = RST && (Ext_Hold || (lu && !Branch_Taken));
    assign IdEx_Bubble = RST && lu && !Branch_Taken && !Ext_Hold;
    assign PC          = pc_q;
    assign Flush       = flush_q;

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc_q;
        cnt_nxt         = cnt;
        pend_nxt        = pend;
        pend_v_nxt      = pend_v;
        redirect        = 1'b0;
        redirect_target = Branch_Target;

        case (state)
            S_RUN: begin
                if (Branch_Taken && !Ext_Hold) begin
                    redirect = 1'b1;
                end else if (Branch_Taken) begin
                    pend_nxt   = Branch_Target;
                    pend_v_nxt = 1'b1;
                    state_nxt  = S_HOLD;
                end else if (Ext_Hold) begin
                    state_nxt = S_HOLD;
                end else if (!lu) begin
                    pc_nxt = UpdatedPC;
                end
            end

            S_HOLD: begin
                if (Ext_Hold) begin
                    if (Branch_Taken) begin
                        pend_nxt   = Branch_Target;
                        pend_v_nxt = 1'b1;
                    end
                end else if (Branch_Taken || pend_v) begin
                    // A branch arriving on the release edge is the newest and wins.
                    redirect        = 1'b1;
                    redirect_target = Branch_Taken ? Branch_Target : pend;
                end else begin
                    pc_nxt    = UpdatedPC;
                    state_nxt = S_RUN;
                end
            end

            S_FLUSH: begin
                if (Branch_Taken) begin
                    redirect = 1'b1;
                end else if (!Ext_Hold) begin
                    pc_nxt = UpdatedPC;
                    if (cnt == 3'd1) begin
                        cnt_nxt   = 3'd0;
                        state_nxt = S_RUN;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
            end

            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = 3'd0;
            end
        endcase

        if (redirect) begin
            pc_nxt     = align_target(redirect_target);
            cnt_nxt    = FLUSH_LOAD;
            pend_v_nxt = 1'b0;
            state_nxt  = S_FLUSH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_RUN;
            pc_q    <= PC_RESET;
            cnt     <= 3'd0;
            pend    <= '0;
            pend_v  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            pend_v  <= pend_v_nxt;
            flush_q <= (state_nxt == S_FLUSH);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Misalign <= 1'b0;
        end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
            Misalign <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios pinned with literals, then random
// traffic compared every cycle against a behavioural model of the fetch controller.
module tb_pc_fetch_ctrl;

    localparam int          FC   = 2;
    localparam logic [31:0] RVEC = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] updated_pc;
    logic        bt = 1'b0;
    logic [31:0] tgt = '0;
    logic        mr = 1'b0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic        hold = 1'b0;
    logic [31:0] pc;
    logic        stall, flush, bubble;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: flush cycles remaining, hold flag, pending redirect.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_in_hold;
    bit          m_pend_v;
    logic [31:0] m_pend;
    bit          m_mis;

    always #5 clk = ~clk;

    // IMEM stand-in: sequential next PC is PC+4, wrapping naturally.
    assign updated_pc = pc + 32'd4;

    pc_fetch_ctrl #(.RESET_VEC(RVEC), .FLUSH_CYCLES(FC), .PC_W(32)) dut (
        .CLK(clk), .RST(rst), .UpdatedPC(updated_pc),
        .Branch_Taken(bt), .Branch_Target(tgt),
        .IdEx_MemRead(mr), .IdEx_Rd(rd), .IfId_Rs1(rs1), .IfId_Rs2(rs2),
        .Ext_Hold(hold), .PC(pc), .Stall(stall), .Flush(flush), .IdEx_Bubble(bubble)
`ifdef PC_ALIGN_CHECK_EN
        , .Misalign(misalign)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        return mr && rd != 0 && (rd == rs1 || rd == rs2);
    endfunction

    function automatic logic [31:0] model_align(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    task automatic model_reset();
        m_pc = RVEC; m_flush_left = 0; m_in_hold = 0; m_pend_v = 0; m_pend = '0; m_mis = 0;
    endtask

    task automatic model_redirect(input logic [31:0] t);
        m_pc = model_align(t);
        if (t[1:0] != 2'b00) m_mis = 1;
        m_flush_left = FC;
        m_pend_v = 0;
        m_in_hold = 0;
    endtask

    // One rising edge of the fetch controller, written from the behavioural rules.
    task automatic model_step();
        if (m_flush_left != 0) begin
            if (bt) model_redirect(tgt);
            else if (!hold) begin
                m_pc = m_pc + 32'd4;
                m_flush_left--;
            end
        end else if (m_in_hold) begin
            if (hold) begin
                if (bt) begin m_pend = tgt; m_pend_v = 1; end
            end else if (bt) model_redirect(tgt);
            else if (m_pend_v) model_redirect(m_pend);
            else begin
                m_pc = m_pc + 32'd4;
                m_in_hold = 0;
            end
        end else begin
            if (bt && !hold) model_redirect(tgt);
            else if (bt) begin m_pend = tgt; m_pend_v = 1; m_in_hold = 1; end
            else if (hold) m_in_hold = 1;
            else if (!model_lu()) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("flush", 32'(flush), 32'(m_flush_left != 0));
        check("stall", 32'(stall), 32'(hold || (model_lu() && !bt)));
        check("bubble", 32'(bubble), 32'(model_lu() && !bt && !hold));
`ifdef PC_ALIGN_CHECK_EN
        check("misalign", 32'(misalign), 32'(m_mis));
`endif
    endtask

    task automatic drive(input bit b, input logic [31:0] t, input bit m, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input bit h);
        @(negedge clk);
        bt = b; tgt = t; mr = m; rd = d; rs1 = s1; rs2 = s2; hold = h;
        #1;
        compare_all();
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asserts reset between edges, checks the immediate effect, then releases away from an edge.
    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        mr = 1; rd = 5'd7; rs1 = 5'd7; hold = 1; bt = 0;
        #1;
        check("rst_pc", pc, RVEC);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        hold = 1; mr = 1; rd = 5'd4; rs1 = 5'd4;
        #1;
        check("reset_pc", pc, 32'd0);
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_bubble", 32'(bubble), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sequential fetch.
        idle(); check("seq_pc0", pc, 32'd0); check("seq_stall0", 32'(stall), 32'd0); step();
        idle(); check("seq_pc4", pc, 32'd4); step();
        // Load-use on rs2 at PC 8.
        drive(0, 32'h0, 1, 5'd5, 5'd0, 5'd5, 0);
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_bubble", 32'(bubble), 32'd1);
        check("lu_pc", pc, 32'd8);
        step();
        idle(); check("lu_hold_pc", pc, 32'd8); step();
        idle(); check("lu_next_pc", pc, 32'd12); step();

        // Redirect to 0x40 from 0x10 with a two-cycle flush.
        drive(1, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0); check("br_pc_before", pc, 32'h10); step();
        idle(); check("br_pc", pc, 32'h40); check("br_flush1", 32'(flush), 32'd1); step();
        idle(); check("br_pc44", pc, 32'h44); check("br_flush2", 32'(flush), 32'd1); step();
        idle(); check("br_pc48", pc, 32'h48); check("br_flush_end", 32'(flush), 32'd0); step();

        // Hold three cycles with a branch captured in the first.
        drive(1, 32'h80, 0, 5'd0, 5'd0, 5'd0, 1); check("hold_stall", 32'(stall), 32'd1); step();
        drive(0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1); check("hold_pc1", pc, 32'h4c); step();
        drive(0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1); check("hold_pc2", pc, 32'h4c); step();
        idle(); check("hold_pc3", pc, 32'h4c); step();
        idle(); check("hold_release_pc", pc, 32'h80); check("hold_release_flush", 32'(flush), 32'd1); step();
        idle(); step();

        // Branch and load-use together: branch wins.
        drive(1, 32'h100, 1, 5'd3, 5'd3, 5'd0, 0);
        check("brlu_bubble", 32'(bubble), 32'd0);
        check("brlu_stall", 32'(stall), 32'd0);
        step();
        idle(); check("brlu_pc", pc, 32'h100); check("brlu_flush", 32'(flush), 32'd1);

        // Asynchronous reset in the middle of the flush window.
        reset_pulse();

`ifdef PC_ALIGN_CHECK_EN
        drive(1, 32'h42, 0, 5'd0, 5'd0, 5'd0, 0); step();
        idle(); check("align_pc", pc, 32'h40); check("align_flag", 32'(misalign), 32'd1);
`endif

        // Randomised traffic against the model, with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) t = $urandom;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
            drive($urandom_range(0, 7) == 0, t, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
